// File: rtl/xtea_cbc_ctrl_if.sv
// Stream and core-side bus for the XTEA block-mode sequencer.
//   in_*       : 64-bit input block stream (valid/ready, in_last marks message end)
//   out_*      : 64-bit result stream (valid/ready, out_last follows in_last)
//   core_*     : start/data/key/decrypt towards the XTEA core, data/ready back
// modport master: the sequencer's view. modport slave: the environment's view
// (block source, result sink and the core itself).
interface xtea_cbc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic         core_start;
  logic         core_decrypt;
  logic [127:0] core_key;
  logic [63:0]  core_data_in;
  logic [63:0]  core_data_out;
  logic         core_ready;

  modport master (
    input  in_valid, in_data, in_last, out_ready, core_data_out, core_ready,
    output in_ready, out_valid, out_data, out_last,
           core_start, core_decrypt, core_key, core_data_in
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, core_data_out, core_ready,
    input  in_ready, out_valid, out_data, out_last,
           core_start, core_decrypt, core_key, core_data_in
  );
endinterface

// File: rtl/xtea_cbc_ctrl.sv
// ECB/CBC block sequencer in front of an XTEA core. One block in flight:
// accept a block, pulse core_start, wait for core_ready (with watchdog),
// chain the result and hold it on the output stream until accepted.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   cfg_load/cfg_*     : per-message key, IV, mode (1=CBC), direction (1=decrypt)
//   bus                : input/output streams and core interface (master view)
//   busy               : sequencer not idle
//   err_timeout        : sticky watchdog flag, cleared by cfg_load
module xtea_cbc_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_load,
  input  logic [127:0]   cfg_key,
  input  logic [63:0]    cfg_iv,
  input  logic           cfg_mode,
  input  logic           cfg_decrypt,
  xtea_cbc_ctrl_if.master bus,
  output logic           busy,
  output logic           err_timeout
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
  state_t state;

  logic [127:0]   key_r;
  logic [63:0]    iv_r, chain_r, blk_r, ct_r, res_r;
  logic           mode_r, dec_r, last_r, start_r, oval_r;
  logic [WDW-1:0] wd_cnt;

  // cfg_load wins over a same-cycle input handshake.
  assign bus.in_ready     = rst_n && (state == IDLE) && !cfg_load;
  assign bus.out_valid    = oval_r;
  assign bus.out_data     = res_r;
  assign bus.out_last     = last_r;
  assign bus.core_start   = start_r;
  assign bus.core_decrypt = dec_r;
  assign bus.core_key     = key_r;
  assign bus.core_data_in = blk_r;
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_r       <= '0;
      iv_r        <= '0;
      chain_r     <= '0;
      blk_r       <= '0;
      ct_r        <= '0;
      res_r       <= '0;
      mode_r      <= 1'b0;
      dec_r       <= 1'b0;
      last_r      <= 1'b0;
      start_r     <= 1'b0;
      oval_r      <= 1'b0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_load) begin
            key_r       <= cfg_key;
            iv_r        <= cfg_iv;
            mode_r      <= cfg_mode;
            dec_r       <= cfg_decrypt;
            chain_r     <= cfg_iv;
            err_timeout <= 1'b0;
          end else if (bus.in_valid) begin
            last_r  <= bus.in_last;
            start_r <= 1'b1;
            state   <= START;
            if (dec_r) begin
              // Ciphertext is the next chaining value, keep it aside.
              blk_r <= bus.in_data;
              ct_r  <= bus.in_data;
            end else begin
              blk_r <= bus.in_data ^ (mode_r ? chain_r : 64'd0);
            end
          end
        end
        START: begin
          start_r <= 1'b0;
          wd_cnt  <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.core_ready) begin
            oval_r <= 1'b1;
            state  <= OUT;
            if (dec_r) begin
              res_r   <= bus.core_data_out ^ (mode_r ? chain_r : 64'd0);
              chain_r <= ct_r;
            end else begin
              res_r   <= bus.core_data_out;
              chain_r <= bus.core_data_out;
            end
          end else if (wd_cnt == WD_MAX) begin
            // Core hung: drop the block and restart the chain from the IV.
            err_timeout <= 1'b1;
            chain_r     <= iv_r;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            oval_r <= 1'b0;
            state  <= IDLE;
            if (last_r) chain_r <= iv_r;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
